// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command front-end: op encodings and FSM states.
package alu_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_RSH = 2'b10;
  localparam logic [1:0] OP_LSH = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/alu_op_mask.sv
// Expands a 2-bit {s0,s1} op code into full-width ALU select masks.
module alu_op_mask #(
  parameter int unsigned LEN = 4
) (
  input  logic [1:0]     op,
  output logic [LEN-1:0] s0,
  output logic [LEN-1:0] s1
);

  assign s0 = {LEN{op[1]}};
  assign s1 = {LEN{op[0]}};

endmodule

// File: rtl/alu_issue_ctrl.sv
// Registered command front-end for the combinational ALU: issues operands and masks,
// waits SETTLE cycles, captures S and offers it on a valid/ready result port.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int unsigned LEN    = 4,
  parameter int unsigned SETTLE = 1,
  parameter int unsigned CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [LEN-1:0]   cmd_a,
  input  logic [LEN-1:0]   cmd_b,
  input  logic             cmd_acc,
  output logic [LEN-1:0]   alu_a,
  output logic [LEN-1:0]   alu_b,
  output logic [LEN-1:0]   alu_s0,
  output logic [LEN-1:0]   alu_s1,
  input  logic [LEN-1:0]   alu_s,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [LEN-1:0]   res_data,
  output logic [1:0]       res_op,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);

  localparam logic [3:0] SETTLE_INIT = 4'(SETTLE - 1);

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [1:0]       op_q, op_d;
  logic [LEN-1:0]   alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [LEN-1:0]   alu_s0_q, alu_s0_d, alu_s1_q, alu_s1_d;
  logic             res_valid_q, res_valid_d;
  logic [LEN-1:0]   res_data_q, res_data_d;
  logic [1:0]       res_op_q, res_op_d;
  logic [CNT_W-1:0] op_count_q, op_count_d;
  logic [LEN-1:0]   mask_s0, mask_s1;
  logic             load;

  alu_op_mask #(
    .LEN (LEN)
  ) u_op_mask (
    .op (cmd_op),
    .s0 (mask_s0),
    .s1 (mask_s1)
  );

  // In DONE a new command may only enter on the same edge the result drains.
  assign cmd_ready = !rst && ((state_q == ST_IDLE) || ((state_q == ST_DONE) && res_ready));
  assign load      = cmd_valid && cmd_ready;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_s0_d    = alu_s0_q;
    alu_s1_d    = alu_s1_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_op_d    = res_op_q;
    op_count_d  = op_count_q;

    unique case (state_q)
      ST_IDLE: ;
      ST_ISSUE: begin
        if (cnt_q == 4'd0) begin
          res_data_d  = alu_s;
          res_op_d    = op_q;
          res_valid_d = 1'b1;
          state_d     = ST_DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_DONE: begin
        if (res_ready) begin
          op_count_d  = op_count_q + CNT_W'(1);
          res_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Accumulate reads res_data_q, i.e. the result being drained this cycle.
    if (load) begin
      alu_a_d  = cmd_acc ? res_data_q : cmd_a;
      alu_b_d  = cmd_b;
      alu_s0_d = mask_s0;
      alu_s1_d = mask_s1;
      op_d     = cmd_op;
      cnt_d    = SETTLE_INIT;
      state_d  = ST_ISSUE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      op_q        <= OP_ADD;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_s0_q    <= '0;
      alu_s1_q    <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_op_q    <= OP_ADD;
      op_count_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_s0_q    <= alu_s0_d;
      alu_s1_q    <= alu_s1_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_op_q    <= res_op_d;
      op_count_q  <= op_count_d;
    end
  end

  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_s0    = alu_s0_q;
  assign alu_s1    = alu_s1_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_op    = res_op_q;
  assign op_count  = op_count_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural ALU; SETTLE=1 and SETTLE=3 instances.
module tb_alu_issue_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  int         checks = 0;
  int         errors = 0;
  int         exp_count = 0;

  // SETTLE=1 instance signals
  logic       cmd_valid, cmd_ready, cmd_acc, res_valid, res_ready, busy;
  logic [1:0] cmd_op, res_op;
  logic [3:0] cmd_a, cmd_b, alu_a, alu_b, alu_s0, alu_s1, alu_s, res_data;
  logic [7:0] op_count;

  // SETTLE=3 instance signals
  logic       cmd_valid3, cmd_ready3, cmd_acc3, res_valid3, res_ready3, busy3;
  logic [1:0] cmd_op3, res_op3;
  logic [3:0] cmd_a3, cmd_b3, alu_a3, alu_b3, alu_s03, alu_s13, alu_s3, res_data3;
  logic [7:0] op_count3;

  always #5 clk = ~clk;

  function automatic logic [3:0] alu_model(logic [3:0] a, logic [3:0] b, logic s0, logic s1);
    if (!s0) return s1 ? a - b : a + b;
    else     return s1 ? {a[2:0], 1'b0} : {1'b0, a[3:1]};
  endfunction

  assign alu_s  = alu_model(alu_a, alu_b, alu_s0[0], alu_s1[0]);
  assign alu_s3 = alu_model(alu_a3, alu_b3, alu_s03[0], alu_s13[0]);

  alu_issue_ctrl #(.LEN(4), .SETTLE(1), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_acc(cmd_acc), .alu_a(alu_a), .alu_b(alu_b),
    .alu_s0(alu_s0), .alu_s1(alu_s1), .alu_s(alu_s), .res_valid(res_valid),
    .res_ready(res_ready), .res_data(res_data), .res_op(res_op), .busy(busy),
    .op_count(op_count)
  );

  alu_issue_ctrl #(.LEN(4), .SETTLE(3), .CNT_W(8)) dut3 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid3), .cmd_ready(cmd_ready3), .cmd_op(cmd_op3),
    .cmd_a(cmd_a3), .cmd_b(cmd_b3), .cmd_acc(cmd_acc3), .alu_a(alu_a3), .alu_b(alu_b3),
    .alu_s0(alu_s03), .alu_s1(alu_s13), .alu_s(alu_s3), .res_valid(res_valid3),
    .res_ready(res_ready3), .res_data(res_data3), .res_op(res_op3), .busy(busy3),
    .op_count(op_count3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one command on the SETTLE=1 instance, check issue and result, then drain.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [3:0] a,
                        input logic [3:0] b, input logic acc, input logic [3:0] exp);
    int n;
    cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b; cmd_acc = acc; res_ready = 1'b0;
    n = 0;
    while (!cmd_ready && n < 20) begin
      step();
      n++;
    end
    chk({tag, "_ready"}, 32'(cmd_ready), 32'd1);
    step();
    cmd_valid = 1'b0;
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    chk({tag, "_s0"}, 32'(alu_s0), op[1] ? 32'hf : 32'h0);
    chk({tag, "_s1"}, 32'(alu_s1), op[0] ? 32'hf : 32'h0);
    chk({tag, "_early"}, 32'(res_valid), 32'd0);
    step();
    chk({tag, "_valid"}, 32'(res_valid), 32'd1);
    chk({tag, "_data"}, 32'(res_data), 32'(exp));
    chk({tag, "_op"}, 32'(res_op), 32'(op));
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    exp_count++;
    chk({tag, "_drop"}, 32'(res_valid), 32'd0);
    chk({tag, "_idle"}, 32'(busy), 32'd0);
    chk({tag, "_cnt"}, 32'(op_count), 32'(exp_count));
    chk({tag, "_hold"}, 32'(res_data), 32'(exp));
  endtask

  initial begin
    int lat;
    rst = 1'b1;
    cmd_valid = 0; cmd_op = 0; cmd_a = 0; cmd_b = 0; cmd_acc = 0; res_ready = 0;
    cmd_valid3 = 0; cmd_op3 = 0; cmd_a3 = 0; cmd_b3 = 0; cmd_acc3 = 0; res_ready3 = 0;
    #12;
    chk("rst_ready", 32'(cmd_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(res_valid), 32'd0);
    chk("rst_data", 32'(res_data), 32'd0);
    chk("rst_alu", 32'({alu_a, alu_b, alu_s0, alu_s1}), 32'd0);
    chk("rst_cnt", 32'(op_count), 32'd0);
    @(negedge clk) rst = 1'b0;
    #1;
    chk("idle_ready", 32'(cmd_ready), 32'd1);

    // Accumulate straight after reset uses A=0
    run_op("acc0", 2'b00, 4'b1111, 4'b0101, 1'b1, 4'b0101);
    run_op("add", 2'b00, 4'b0011, 4'b0011, 1'b0, 4'b0110);
    run_op("sub_borrow", 2'b01, 4'b0011, 4'b0101, 1'b0, 4'b1110);
    run_op("sub", 2'b01, 4'b0101, 4'b0011, 1'b0, 4'b0010);
    run_op("rsh", 2'b10, 4'b0011, 4'b0000, 1'b0, 4'b0001);
    run_op("lsh", 2'b11, 4'b0011, 4'b0000, 1'b0, 4'b0110);
    run_op("lsh_msb", 2'b11, 4'b1000, 4'b0000, 1'b0, 4'b0000);
    run_op("chain0", 2'b00, 4'b0011, 4'b0011, 1'b0, 4'b0110);
    run_op("chain1", 2'b00, 4'b1111, 4'b0001, 1'b1, 4'b0111);
    run_op("chain2", 2'b00, 4'b1111, 4'b1001, 1'b1, 4'b0000);

    // Backpressure with a second command waiting
    cmd_valid = 1'b1; cmd_op = 2'b00; cmd_a = 4'b0001; cmd_b = 4'b0001; cmd_acc = 1'b0;
    step();
    cmd_op = 2'b01; cmd_a = 4'b0111; cmd_b = 4'b0010;
    step();
    chk("bp_valid", 32'(res_valid), 32'd1);
    for (int i = 0; i < 4; i++) begin
      chk("bp_data", 32'(res_data), 32'b0010);
      chk("bp_op", 32'(res_op), 32'b00);
      chk("bp_ready", 32'(cmd_ready), 32'd0);
      step();
    end
    res_ready = 1'b1;
    #1;
    chk("bp_pass", 32'(cmd_ready), 32'd1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0; res_ready = 1'b0;
    exp_count++;
    chk("bp_cnt", 32'(op_count), 32'(exp_count));
    chk("bp_gap", 32'(res_valid), 32'd0);
    chk("bp_busy", 32'(busy), 32'd1);
    step();
    chk("bp2_valid", 32'(res_valid), 32'd1);
    chk("bp2_data", 32'(res_data), 32'b0101);
    chk("bp2_op", 32'(res_op), 32'b01);
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    exp_count++;
    chk("bp2_cnt", 32'(op_count), 32'(exp_count));

    // Asynchronous reset in the middle of ISSUE
    cmd_valid = 1'b1; cmd_op = 2'b11; cmd_a = 4'b1010; cmd_b = 4'b0110; cmd_acc = 1'b0;
    step();
    cmd_valid = 1'b0;
    chk("mid_busy", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("mid_alu", 32'({alu_a, alu_b, alu_s0, alu_s1}), 32'd0);
    chk("mid_busy0", 32'(busy), 32'd0);
    chk("mid_ready0", 32'(cmd_ready), 32'd0);
    chk("mid_cnt", 32'(op_count), 32'd0);
    chk("mid_data", 32'(res_data), 32'd0);
    step();
    @(negedge clk) rst = 1'b0;
    exp_count = 0;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("post_valid", 32'(res_valid), 32'd0);
      chk("post_busy", 32'(busy), 32'd0);
    end

    // SETTLE=3 accept-to-valid latency
    cmd_valid3 = 1'b1; cmd_op3 = 2'b00; cmd_a3 = 4'b0100; cmd_b3 = 4'b0101; cmd_acc3 = 1'b0;
    step();
    cmd_valid3 = 1'b0;
    lat = 1;
    while (!res_valid3 && lat < 10) begin
      step();
      lat++;
    end
    lat--;
    chk("s3_latency", 32'(lat), 32'd3);
    chk("s3_data", 32'(res_data3), 32'b1001);
    res_ready3 = 1'b1;
    step();
    res_ready3 = 1'b0;
    chk("s3_cnt", 32'(op_count3), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
